viexo_tmds_rx: RTL and testbench

Single-channel TMDS receiver: deserialises one TMDS bit stream sampled at the bit clock, finds the 10-bit symbol boundary by hunting for control tokens with bit-slip, and decodes each symbol into 8-bit pixel data or a 2-bit control word plus data-enable. It is the receive-side counterpart to `viexo_tmds`. It is used three times (B/G/R) in loopback and capture paths, with channel 0 recovering hsync/vsync from `c`.

---
 rtl/viexo_tmds_pkg.sv | 18 +
 rtl/viexo_tmds_dec.sv | 43 ++++
 rtl/viexo_tmds_rx.sv | 193 +++++++++++++++++++
 tb/tb_viexo_tmds_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/viexo_tmds_pkg.sv
// Shared definitions for the TMDS transmit/receive pair: symbol width,
// the four control tokens and the receiver alignment state encoding.
package viexo_tmds_pkg;

    localparam int TMDS_SYM_W = 10;

    localparam logic [TMDS_SYM_W-1:0] TOK_C00 = 10'b1101010100;
    localparam logic [TMDS_SYM_W-1:0] TOK_C01 = 10'b0010101011;
    localparam logic [TMDS_SYM_W-1:0] TOK_C10 = 10'b0101010100;
    localparam logic [TMDS_SYM_W-1:0] TOK_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_t;

endpackage

// File: rtl/viexo_tmds_dec.sv
// Combinational TMDS symbol decoder: classifies a 10-bit symbol as a control
// token (returning its 2-bit control word) and always produces the 8-bit data
// decode so the caller can pick whichever applies.
module viexo_tmds_dec
    import viexo_tmds_pkg::*;
(
    input  logic [TMDS_SYM_W-1:0] i_sym,
    output logic                  o_is_token,
    output logic [1:0]            o_c,
    output logic [7:0]            o_d
);

    logic       w_q8;
    logic [7:0] w_q_lo;

    // Token match against the four fixed control symbols.
    always_comb begin
        o_is_token = 1'b1;
        o_c        = 2'b00;
        case (i_sym)
            TOK_C00: o_c = 2'b00;
            TOK_C01: o_c = 2'b01;
            TOK_C10: o_c = 2'b10;
            TOK_C11: o_c = 2'b11;
            default: begin
                o_is_token = 1'b0;
                o_c        = 2'b00;
            end
        endcase
    end

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
    always_comb begin
        w_q8   = i_sym[8];
        w_q_lo = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
        o_d    = 8'h00;
        o_d[0] = w_q_lo[0];
        for (int i = 1; i < 8; i++) begin
            o_d[i] = w_q8 ? (w_q_lo[i] ^ w_q_lo[i-1]) : ~(w_q_lo[i] ^ w_q_lo[i-1]);
        end
    end

endmodule

// File: rtl/viexo_tmds_rx.sv
// Single-channel TMDS receiver: bit-serial deserialiser with control-token
// word alignment (bit-slip hunting), lock supervision and symbol decode.
// Optional build macro VIEXO_TMDS_RX_STATS_EN adds saturating slip/drop
// counters on outputs slips and drops.
module viexo_tmds_rx
    import viexo_tmds_pkg::*;
#(
    parameter int LOCK_RUN     = 8,
    parameter int TIMEOUT_SYMS = 4095
)(
    input  logic       aclk,
    input  logic       areset,
    input  logic       channel,
    output logic [7:0] d,
    output logic [1:0] c,
    output logic       de,
    output logic       valid,
    output logic       locked
`ifdef VIEXO_TMDS_RX_STATS_EN
    ,
    output logic [7:0] slips,
    output logic [7:0] drops
`endif
);

    localparam logic [3:0]  LOCK_RUN_L = 4'(LOCK_RUN);
    localparam logic [11:0] TMO_L      = 12'(TIMEOUT_SYMS);

    logic [TMDS_SYM_W-1:0] r_sr;
    logic [3:0]            r_phase;
    logic                  r_stall;
    rx_state_t             r_state;
    logic [3:0]            r_run;
    logic [11:0]           r_tmo;
    logic [7:0]            r_d;
    logic [1:0]            r_c;
    logic                  r_de;
    logic                  r_valid;

    rx_state_t             w_state_nxt;
    logic [3:0]            w_run_nxt;
    logic [11:0]           w_tmo_nxt;
    logic                  w_slip;
    logic                  w_strobe;
    logic                  w_bnd;
    logic [TMDS_SYM_W-1:0] w_sym;
    logic                  w_tok;
    logic [1:0]            w_c;
    logic [7:0]            w_d;

    // The symbol completes with the bit being sampled at the phase-9 edge.
    assign w_sym = {channel, r_sr[TMDS_SYM_W-1:1]};
    assign w_bnd = (r_phase == 4'd9);

    viexo_tmds_dec u_dec (
        .i_sym      (w_sym),
        .o_is_token (w_tok),
        .o_c        (w_c),
        .o_d        (w_d)
    );

    // Shift register and symbol phase; a slip holds phase at 0 one extra cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_sr    <= '0;
            r_phase <= 4'd0;
            r_stall <= 1'b0;
        end else begin
            r_sr    <= w_sym;
            r_stall <= w_slip;
            if (r_stall || w_bnd) r_phase <= 4'd0;
            else                  r_phase <= r_phase + 4'd1;
        end
    end

    // Alignment FSM state and run/timeout counters.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_HUNT;
            r_run   <= 4'd0;
            r_tmo   <= 12'd0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    // Next-state logic, evaluated only at symbol boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_tmo_nxt   = r_tmo;
        w_slip      = 1'b0;
        w_strobe    = 1'b0;
        if (w_bnd) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_tok) begin
                        w_run_nxt   = 4'd1;
                        w_tmo_nxt   = 12'd0;
                        w_state_nxt = (LOCK_RUN_L <= 4'd1) ? ST_LOCKED : ST_CHECK;
                    end else begin
                        w_slip = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_tok) begin
                        w_run_nxt = r_run + 4'd1;
                        if ((r_run + 4'd1) >= LOCK_RUN_L) begin
                            w_state_nxt = ST_LOCKED;
                            w_tmo_nxt   = 12'd0;
                        end
                    end else begin
                        w_state_nxt = ST_HUNT;
                        w_run_nxt   = 4'd0;
                        w_slip      = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    w_strobe = 1'b1;
                    if (w_tok) begin
                        w_tmo_nxt = 12'd0;
                    end else if ((r_tmo + 12'd1) == TMO_L) begin
                        // Timeout: drop lock without a strobe and without slipping.
                        w_state_nxt = ST_HUNT;
                        w_run_nxt   = 4'd0;
                        w_tmo_nxt   = 12'd0;
                        w_strobe    = 1'b0;
                    end else begin
                        w_tmo_nxt = r_tmo + 12'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_run_nxt   = 4'd0;
                    w_tmo_nxt   = 12'd0;
                end
            endcase
        end
    end

    // Decoded outputs register on locked boundaries and hold in between.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_d     <= 8'h00;
            r_c     <= 2'b00;
            r_de    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_strobe;
            if (w_strobe) begin
                if (w_tok) begin
                    r_de <= 1'b0;
                    r_c  <= w_c;
                end else begin
                    r_de <= 1'b1;
                    r_c  <= 2'b00;
                    r_d  <= w_d;
                end
            end
        end
    end

    assign d      = r_d;
    assign c      = r_c;
    assign de     = r_de;
    assign valid  = r_valid;
    assign locked = (r_state == ST_LOCKED);

`ifdef VIEXO_TMDS_RX_STATS_EN
    logic [7:0] r_slips;
    logic [7:0] r_drops;
    logic       w_drop;

    assign w_drop = (r_state == ST_LOCKED) && (w_state_nxt == ST_HUNT);

    // Saturating slip and lock-loss event counters.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_slips <= 8'd0;
            r_drops <= 8'd0;
        end else begin
            if (w_slip && (r_slips != 8'hFF)) r_slips <= r_slips + 8'd1;
            if (w_drop && (r_drops != 8'hFF)) r_drops <= r_drops + 8'd1;
        end
    end

    assign slips = r_slips;
    assign drops = r_drops;
`endif

endmodule

// File: tb/tb_viexo_tmds_rx.sv
// Scoreboard bench for viexo_tmds_rx: stimulus pushes the expected
// {de, c, d} for every locked symbol; a monitor pops on each valid strobe.
// Slip/drop counters are checked when VIEXO_TMDS_RX_STATS_EN is defined.
module tb_viexo_tmds_rx;
    import viexo_tmds_pkg::*;

    logic       aclk = 1'b0;
    logic       areset;
    logic       channel;
    logic [7:0] d;
    logic [1:0] c;
    logic       de;
    logic       valid;
    logic       locked;
`ifdef VIEXO_TMDS_RX_STATS_EN
    logic [7:0] slips;
    logic [7:0] drops;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [10:0] exp_q[$];

    viexo_tmds_rx #(.LOCK_RUN(8), .TIMEOUT_SYMS(4095)) dut (
        .aclk    (aclk),
        .areset  (areset),
        .channel (channel),
        .d       (d),
        .c       (c),
        .de      (de),
        .valid   (valid),
        .locked  (locked)
`ifdef VIEXO_TMDS_RX_STATS_EN
        ,
        .slips   (slips),
        .drops   (drops)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest pending expectation.
    always begin
        @(posedge aclk);
        #1;
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL strobe_unexpected: got de=%0b c=%0b d=0x%0h expected no strobe at %0t",
                         de, c, d, $time);
            end else begin
                chk("strobe_de_c_d", {21'd0, de, c, d}, {21'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_bits(input logic [9:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            channel = s[i];
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic send_sym(input logic [9:0] s);
        send_bits(s, 10);
    endtask

    task automatic push(input logic e_de, input logic [1:0] e_c, input logic [7:0] e_d);
        exp_q.push_back({e_de, e_c, e_d});
    endtask

    task automatic chk_stats(input string name, input logic [7:0] e_slips, input logic [7:0] e_drops);
`ifdef VIEXO_TMDS_RX_STATS_EN
        chk({name, "_slips"}, {24'd0, slips}, {24'd0, e_slips});
        chk({name, "_drops"}, {24'd0, drops}, {24'd0, e_drops});
`else
        if (e_slips != e_drops) begin end
`endif
    endtask

    task automatic do_reset();
        areset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            channel = 1'($urandom);
            @(posedge aclk);
            #2;
            chk("rst_hold_outs", {19'd0, d, c, de, valid, locked}, 32'd0);
        end
        areset = 1'b0;
        #1;
        chk("rst_release_outs", {19'd0, d, c, de, valid, locked}, 32'd0);
        chk_stats("rst", 8'd0, 8'd0);
    endtask

    // Aligned C00 stream from phase 0: lock on the 8th token boundary.
    task automatic relock_aligned(input string name);
        for (int i = 0; i < 8; i++) begin
            send_sym(TOK_C00);
            if (i == 6) chk({name, "_locked_after7"}, {31'd0, locked}, 32'd0);
        end
        chk({name, "_locked_after8"}, {31'd0, locked}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset  = 1'b1;
        channel = 1'b0;
        #3;

        // Reset behaviour.
        do_reset();

        // Aligned token stream.
        relock_aligned("aligned");
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 2'b00, 8'h00);
            send_sym(TOK_C00);
        end
        chk_stats("aligned", 8'd0, 8'd0);

        // Stream offset by 3 bits: three slips, then 8 tokens to lock.
        do_reset();
        send_bits(10'h000, 3);
        for (int i = 0; i < 11; i++) begin
            send_sym(TOK_C00);
            if (i == 9) chk("offset_locked_after10", {31'd0, locked}, 32'd0);
        end
        chk("offset_locked_after11", {31'd0, locked}, 32'd1);
        chk_stats("offset", 8'd3, 8'd0);

        // Data decode, then control words with d held.
        push(1'b1, 2'b00, 8'h00);
        send_sym(10'h100);
        push(1'b1, 2'b00, 8'hFF);
        send_sym(10'h200);
        push(1'b0, 2'b01, 8'hFF);
        send_sym(TOK_C01);
        push(1'b0, 2'b10, 8'hFF);
        send_sym(TOK_C10);
        push(1'b0, 2'b11, 8'hFF);
        send_sym(TOK_C11);

        // 4094 data symbols then a token: lock is kept.
        for (int i = 0; i < 4094; i++) begin
            push(1'b1, 2'b00, 8'h00);
            send_sym(10'h100);
        end
        chk("tmo_4094_locked", {31'd0, locked}, 32'd1);
        push(1'b0, 2'b00, 8'h00);
        send_sym(TOK_C00);
        chk("tmo_token_locked", {31'd0, locked}, 32'd1);

        // 4095 data symbols: lock drops after the last, with no strobe for it.
        for (int i = 0; i < 4095; i++) begin
            if (i < 4094) push(1'b1, 2'b00, 8'h00);
            send_sym(10'h100);
            if (i == 4093) chk("tmo_before_last_locked", {31'd0, locked}, 32'd1);
        end
        chk("tmo_drop_locked", {31'd0, locked}, 32'd0);
        chk("tmo_drop_hold", {21'd0, de, c, d}, {21'd0, 1'b1, 2'b00, 8'h00});
        chk_stats("tmo", 8'd3, 8'd1);

        // Relock without slipping, then reset in the middle of a symbol.
        relock_aligned("relock");
        push(1'b0, 2'b10, 8'h00);
        send_sym(TOK_C10);
        send_bits(TOK_C00, 4);
        areset = 1'b1;
        #1;
        chk("midrst_locked_valid", {30'd0, locked, valid}, 32'd0);
        chk("midrst_outs", {21'd0, de, c, d}, 32'd0);
        chk_stats("midrst", 8'd0, 8'd0);
        @(posedge aclk);
        #2;
        @(posedge aclk);
        #2;
        areset = 1'b0;
        relock_aligned("midrst");
        push(1'b0, 2'b01, 8'h00);
        send_sym(TOK_C01);

        repeat (3) begin
            @(posedge aclk);
            #2;
        end
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
